exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl.sv | 143 ++++++++++++++
 tb/tb_exc_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencing for a single-issue core: sync faults, external IRQ entry, ERET return, double-fault halt.
// Optional two-level nesting of IRQs inside a handler is enabled by defining EXC_NESTED_IRQ_EN.
module exc_ctrl #(
   parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ExtIRQ,
   input  logic        NotAnInstr,
   input  logic        ERet,
   input  logic [63:0] PC,
   output logic        PCRedirect,
   output logic [63:0] PCTarget,
   output logic        Flush,
   output logic        ExcAck,
   output logic        ExtIAck,
   output logic [63:0] ELR,
   output logic [3:0]  ESR,
   output logic        InHandler,
   output logic        DoubleFault
);

   typedef enum logic [2:0] {S_RUN, S_ENTER, S_HANDLER, S_RETURN, S_HALT} state_t;

   state_t      state, state_nxt;
   logic        irq_pend, cause_irq, cause_nxt, df_nxt;
   logic [63:0] elr_nxt;
   logic [3:0]  esr_nxt;
`ifdef EXC_NESTED_IRQ_EN
   logic [63:0] elr2, elr2_nxt;
   logic [3:0]  esr2, esr2_nxt;
   logic        depth, depth_nxt, hexec, hexec_nxt;
`endif

   always_comb begin
      state_nxt  = state;
      elr_nxt    = ELR;
      esr_nxt    = ESR;
      cause_nxt  = cause_irq;
      df_nxt     = DoubleFault;
      PCRedirect = 1'b0;
      PCTarget   = '0;
      Flush      = 1'b0;
      ExcAck     = 1'b0;
      ExtIAck    = 1'b0;
`ifdef EXC_NESTED_IRQ_EN
      elr2_nxt   = elr2;
      esr2_nxt   = esr2;
      depth_nxt  = depth;
      hexec_nxt  = hexec;
`endif
      case (state)
         S_RUN: begin
            // ERET outside a handler is treated as a sync fault, same as a bad opcode
            if (NotAnInstr || ERet) begin
               Flush = 1'b1; elr_nxt = PC; esr_nxt = 4'b0010; cause_nxt = 1'b0; state_nxt = S_ENTER;
            end else if (irq_pend || ExtIRQ) begin
               Flush = 1'b1; elr_nxt = PC; esr_nxt = 4'b0001; cause_nxt = 1'b1; state_nxt = S_ENTER;
            end
         end
         S_ENTER: begin
            PCRedirect = 1'b1;
            PCTarget   = EXC_VECTOR;
            ExcAck     = 1'b1;
            Flush      = 1'b1;
            ExtIAck    = cause_irq;
            state_nxt  = S_HANDLER;
`ifdef EXC_NESTED_IRQ_EN
            hexec_nxt  = 1'b0;
`endif
         end
         S_HANDLER: begin
`ifdef EXC_NESTED_IRQ_EN
            hexec_nxt = 1'b1;
`endif
            if (NotAnInstr) begin
               Flush = 1'b1; state_nxt = S_HALT; df_nxt = 1'b1; esr_nxt = 4'b1000;
            end else if (ERet) begin
               state_nxt = S_RETURN;
            end
`ifdef EXC_NESTED_IRQ_EN
            else if (hexec && (irq_pend || ExtIRQ)) begin
               Flush = 1'b1;
               if (depth) begin
                  // no third save slot: a third-level event is fatal
                  state_nxt = S_HALT; df_nxt = 1'b1; esr_nxt = 4'b1000;
               end else begin
                  elr2_nxt = ELR; esr2_nxt = ESR; elr_nxt = PC; esr_nxt = 4'b0001;
                  cause_nxt = 1'b1; depth_nxt = 1'b1; state_nxt = S_ENTER;
               end
            end
`endif
         end
         S_RETURN: begin
            PCRedirect = 1'b1;
            PCTarget   = ELR;
            Flush      = 1'b1;
            state_nxt  = S_RUN;
`ifdef EXC_NESTED_IRQ_EN
            if (depth) begin
               elr_nxt = elr2; esr_nxt = esr2; depth_nxt = 1'b0; hexec_nxt = 1'b1; state_nxt = S_HANDLER;
            end
`endif
         end
         S_HALT: begin
            PCRedirect = 1'b1;
            PCTarget   = PC;
            Flush      = 1'b1;
         end
         default: state_nxt = S_RUN;
      endcase
      InHandler = (state == S_HANDLER);
      // reset cycle: nothing leaves the block, so no acknowledge can slip out mid-sequence
      if (reset) begin
         PCRedirect = 1'b0; PCTarget = '0; Flush = 1'b0; ExcAck = 1'b0; ExtIAck = 1'b0; InHandler = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_RUN;
         irq_pend    <= 1'b0;
         cause_irq   <= 1'b0;
         ELR         <= '0;
         ESR         <= '0;
         DoubleFault <= 1'b0;
`ifdef EXC_NESTED_IRQ_EN
         elr2 <= '0; esr2 <= '0; depth <= 1'b0; hexec <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         irq_pend    <= ExtIRQ | (irq_pend & ~ExtIAck);
         cause_irq   <= cause_nxt;
         ELR         <= elr_nxt;
         ESR         <= esr_nxt;
         DoubleFault <= df_nxt;
`ifdef EXC_NESTED_IRQ_EN
         elr2 <= elr2_nxt; esr2 <= esr2_nxt; depth <= depth_nxt; hexec <= hexec_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios then random stimulus, all checked each cycle against a behavioural model.
module tb_exc_ctrl;
   localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;

   logic        clk = 1'b0, reset, ExtIRQ, NotAnInstr, ERet;
   logic [63:0] PC;
   logic        PCRedirect, Flush, ExcAck, ExtIAck, InHandler, DoubleFault;
   logic [63:0] PCTarget, ELR;
   logic [3:0]  ESR;

   exc_ctrl #(.EXC_VECTOR(VEC)) dut (
      .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .NotAnInstr(NotAnInstr), .ERet(ERet), .PC(PC),
      .PCRedirect(PCRedirect), .PCTarget(PCTarget), .Flush(Flush), .ExcAck(ExcAck), .ExtIAck(ExtIAck),
      .ELR(ELR), .ESR(ESR), .InHandler(InHandler), .DoubleFault(DoubleFault)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   // Reference: where the core is in the exception life cycle, plus saved context
   typedef enum int {RUNNING, ENTERING, IN_HANDLER, RETURNING, HALTED} phase_t;
   phase_t      ph = RUNNING;
   bit          pend = 0, took_irq = 0, df = 0;
   logic [63:0] sv_elr = '0;
   logic [3:0]  sv_esr = '0;

   task automatic step(input bit rst, input bit nai, input bit er, input bit irq, input logic [63:0] pc);
      bit e_red, e_fl, e_ack, e_iack;
      logic [63:0] e_tgt;
      reset = rst; NotAnInstr = nai; ERet = er; ExtIRQ = irq; PC = pc;
      #1;
      e_red = 0; e_fl = 0; e_ack = 0; e_iack = 0; e_tgt = '0;
      if (!rst) begin
         if (ph == RUNNING)    e_fl = nai | er | pend | irq;
         if (ph == ENTERING)   begin e_red = 1; e_tgt = VEC; e_ack = 1; e_fl = 1; e_iack = took_irq; end
         if (ph == IN_HANDLER) e_fl = nai;
         if (ph == RETURNING)  begin e_red = 1; e_tgt = sv_elr; e_fl = 1; end
         if (ph == HALTED)     begin e_red = 1; e_tgt = pc; e_fl = 1; end
      end
      chk("PCRedirect", PCRedirect, e_red);
      chk("PCTarget", PCTarget, e_tgt);
      chk("Flush", Flush, e_fl);
      chk("ExcAck", ExcAck, e_ack);
      chk("ExtIAck", ExtIAck, e_iack);
      chk("InHandler", InHandler, !rst && ph == IN_HANDLER);
      chk("ELR", ELR, sv_elr);
      chk("ESR", ESR, sv_esr);
      chk("DoubleFault", DoubleFault, df);
      @(posedge clk);
      if (rst) begin
         ph = RUNNING; pend = 0; took_irq = 0; df = 0; sv_elr = '0; sv_esr = '0;
      end else begin
         if (ph == RUNNING && (nai || er)) begin
            sv_elr = pc; sv_esr = 4'b0010; took_irq = 0; ph = ENTERING;
         end else if (ph == RUNNING && (pend || irq)) begin
            sv_elr = pc; sv_esr = 4'b0001; took_irq = 1; ph = ENTERING;
         end else if (ph == ENTERING) ph = IN_HANDLER;
         else if (ph == IN_HANDLER && nai) begin
            ph = HALTED; df = 1; sv_esr = 4'b1000;
         end else if (ph == IN_HANDLER && er) ph = RETURNING;
         else if (ph == RETURNING) ph = RUNNING;
         pend = irq || (pend && !e_iack);
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic [63:0] pc); step(0, 0, 0, 0, pc); endtask

   initial begin
      reset = 1; ExtIRQ = 0; NotAnInstr = 0; ERet = 0; PC = '0;
      @(negedge clk);
      step(1, 0, 0, 1, 64'h10);
      step(1, 1, 0, 0, 64'h14);
      idle(64'h20);
      chk("rst_elr", ELR, 64'h0);

      // invalid opcode in RUN
      step(0, 1, 0, 0, 64'h40);
      chk("sync_elr", ELR, 64'h40);
      chk("sync_esr", ESR, 4'b0010);
      idle(64'h44); idle(64'hD8);
      step(0, 0, 1, 0, 64'hDC); idle(64'hE0); idle(64'h40);

      // single-cycle IRQ pulse
      step(0, 0, 0, 1, 64'h80);
      chk("irq_elr", ELR, 64'h80);
      chk("irq_esr", ESR, 4'b0001);
      idle(64'h84); idle(64'hD8);
      step(0, 0, 1, 0, 64'hDC); idle(64'hE0); idle(64'h80); idle(64'h84);

      // fault and IRQ together: fault first, IRQ after return
      step(0, 1, 0, 1, 64'h100);
      chk("prio_esr", ESR, 4'b0010);
      idle(64'h104); idle(64'hD8);
      step(0, 0, 0, 1, 64'hDC);
      idle(64'hE0);
      step(0, 0, 1, 0, 64'hE4); idle(64'hE8);
      idle(64'h100);
      chk("prio_irq_esr", ESR, 4'b0001);
      idle(64'h104); idle(64'hD8);
      step(0, 0, 1, 0, 64'hDC); idle(64'hE0); idle(64'h104);

      // double fault, then reset
      step(0, 1, 0, 0, 64'h200); idle(64'h204); idle(64'hD8);
      step(0, 1, 0, 0, 64'hDC);
      chk("df_flag", DoubleFault, 1'b1);
      chk("df_esr", ESR, 4'b1000);
      step(0, 0, 0, 1, 64'h300); idle(64'h304);
      step(1, 0, 0, 0, 64'h308); idle(64'h0);

      // reset landing on ENTER
      step(0, 0, 0, 1, 64'h400);
      step(1, 0, 0, 0, 64'h404);
      idle(64'h408); idle(64'h40C);
      chk("rst_enter_elr", ELR, 64'h0);

      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(99) < 1, $urandom_range(99) < 5, $urandom_range(99) < 15,
              $urandom_range(99) < 10, {$urandom, $urandom});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
